// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// the load result-source code and the data-memory wait FSM states.
package pipeline_pkg;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/forward_unit.sv
// Combinational operand-forwarding select for the two EX-stage ALU sources.
// MEM results take precedence over WB results; x0 is never forwarded.
module forward_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] i_rs1_e,
    input  logic [4:0] i_rs2_e,
    input  logic [4:0] i_rd_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_reg_write_m,
    input  logic       i_reg_write_w,
    output logic [1:0] o_forward_a,
    output logic [1:0] o_forward_b
);

    logic w_m_valid;
    logic w_w_valid;

    assign w_m_valid = i_reg_write_m && (i_rd_m != 5'd0);
    assign w_w_valid = i_reg_write_w && (i_rd_w != 5'd0);

    always_comb begin
        o_forward_a = FWD_REG;
        if (w_m_valid && (i_rd_m == i_rs1_e))
            o_forward_a = FWD_MEM;
        else if (w_w_valid && (i_rd_w == i_rs1_e))
            o_forward_a = FWD_WB;
    end

    always_comb begin
        o_forward_b = FWD_REG;
        if (w_m_valid && (i_rd_m == i_rs2_e))
            o_forward_b = FWD_MEM;
        else if (w_w_valid && (i_rd_w == i_rs2_e))
            o_forward_b = FWD_WB;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: forwarding, load-use and branch
// hazards, data-memory wait-state stalling with timeout, and stall statistics.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic             StatClr,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemBusy,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount
);

    localparam int WCNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [WCNT_W-1:0] LIMIT_VAL   = WCNT_W'(WAIT_LIMIT);
    localparam logic [WCNT_W-1:0] LIMIT_M1    = WCNT_W'(WAIT_LIMIT - 1);

    mem_state_e        r_state;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic              r_mem_busy;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;
    logic              w_lw_stall;
    logic              w_mem_stall;
    logic              w_timeout_set;
    logic              w_stall_fd;

    forward_unit u_forward_unit (
        .i_rs1_e       (Rs1E),
        .i_rs2_e       (Rs2E),
        .i_rd_m        (RdM),
        .i_rd_w        (RdW),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_forward_a   (w_fwd_a),
        .o_forward_b   (w_fwd_b)
    );

    assign w_lw_stall = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));

    // The release cycle (WAIT with ready) is deliberately stall-free.
    assign w_mem_stall = ((r_state == IDLE) && MemReqM && !MemReadyM) ||
                         ((r_state == WAIT) && !MemReadyM);

    // A memory stall freezes everything, so a held branch or load-use is
    // re-evaluated on release; otherwise a taken branch overrides load-use.
    assign w_stall_fd = w_mem_stall || (w_lw_stall && !PCSrcE);

    // Outputs are forced idle while reset is held low.
    assign StallF    = reset && w_stall_fd;
    assign StallD    = reset && w_stall_fd;
    assign StallE    = reset && w_mem_stall;
    assign StallM    = reset && w_mem_stall;
    assign FlushW    = reset && w_mem_stall;
    assign FlushD    = reset && !w_mem_stall && PCSrcE;
    assign FlushE    = reset && !w_mem_stall && (PCSrcE || w_lw_stall);
    assign ForwardAE = reset ? w_fwd_a : FWD_REG;
    assign ForwardBE = reset ? w_fwd_b : FWD_REG;

    assign w_timeout_set = (r_state == WAIT) && !MemReadyM &&
                           (r_wait_cnt >= LIMIT_M1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_mem_busy <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (MemReqM && !MemReadyM) begin
                        r_state    <= WAIT;
                        r_mem_busy <= 1'b1;
                        r_wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (MemReadyM) begin
                        r_state    <= IDLE;
                        r_mem_busy <= 1'b0;
                    end else if (r_wait_cnt != LIMIT_VAL) begin
                        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_mem_busy <= 1'b0;
                end
            endcase

            if (StatClr)
                r_timeout <= 1'b0;
            else if (w_timeout_set)
                r_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stall_cnt <= '0;
        else if (StatClr)
            r_stall_cnt <= '0;
        else if (w_stall_fd && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign MemBusy    = r_mem_busy;
    assign MemTimeout = r_timeout;
    assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the hazard rules.
module tb_pipeline_ctrl;

    localparam int WL = 4;
    localparam int CW = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]    ResultSrcE;
    logic          PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM, StatClr;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          MemBusy, MemTimeout;
    logic [CW-1:0] StallCount;

    always #5 clk = ~clk;

    pipeline_ctrl #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .MemReqM    (MemReqM),
        .MemReadyM  (MemReadyM),
        .StatClr    (StatClr),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushW     (FlushW),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .MemBusy    (MemBusy),
        .MemTimeout (MemTimeout),
        .StallCount (StallCount)
    );

    int chk_cnt = 0;
    int err_cnt = 0;

    // Reference state: is an access outstanding, how long it has waited,
    // the sticky timeout flag and the number of front-end stall cycles.
    bit m_waiting;
    int m_wait;
    bit m_timeout;
    int m_stall_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_waiting   = 0;
        m_wait      = 0;
        m_timeout   = 0;
        m_stall_cnt = 0;
    endtask

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        ResultSrcE = 2'b00;
        {PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM, StatClr} = '0;
    endtask

    // Called just after a falling edge with inputs applied; checks every
    // output against the model, advances the model across the rising edge
    // and returns at the next falling edge.
    task automatic step();
        bit lw, ms, e_sf, e_fd, e_fe;
        logic [1:0] e_fa, e_fb;
        #2;
        lw = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        ms = m_waiting ? !MemReadyM : (MemReqM && !MemReadyM);
        e_sf = ms || (lw && !PCSrcE);
        e_fd = !ms && PCSrcE;
        e_fe = !ms && (PCSrcE || lw);
        e_fa = ref_fwd(Rs1E);
        e_fb = ref_fwd(Rs2E);
        if (!reset) begin
            {ms, e_sf, e_fd, e_fe} = '0;
            e_fa = 2'b00;
            e_fb = 2'b00;
        end
        check("StallF", StallF, e_sf);
        check("StallD", StallD, e_sf);
        check("StallE", StallE, ms);
        check("StallM", StallM, ms);
        check("FlushW", FlushW, ms);
        check("FlushD", FlushD, e_fd);
        check("FlushE", FlushE, e_fe);
        check("ForwardAE", ForwardAE, e_fa);
        check("ForwardBE", ForwardBE, e_fb);
        check("MemBusy", MemBusy, m_waiting);
        check("MemTimeout", MemTimeout, m_timeout);
        check("StallCount", StallCount, m_stall_cnt);
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            if (m_waiting) begin
                if (MemReadyM) begin
                    m_waiting = 0;
                end else begin
                    if (m_wait < WL) m_wait++;
                    if (m_wait == WL) m_timeout = 1;
                end
            end else if (MemReqM && !MemReadyM) begin
                m_waiting = 1;
                m_wait    = 0;
            end
            if (StatClr) m_timeout = 0;
            if (StatClr) m_stall_cnt = 0;
            else if (e_sf && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        model_reset();
        // Hazard-provoking inputs while held in reset must not leak out.
        Rs1E = 5; RdM = 5; RegWriteM = 1; Rs2E = 3; RdW = 3; RegWriteW = 1;
        ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; PCSrcE = 1; MemReqM = 1;
        @(negedge clk);
        #1;
        check("rst_fwd_a", ForwardAE, 2'b00);
        check("rst_stallf", StallF, 1'b0);
        check("rst_flushd", FlushD, 1'b0);
        step();
        reset = 1'b1;
        clear_inputs();
        step();

        // Forwarding priority: MEM over WB, x0 excluded.
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
        #1; check("fwd_mem", ForwardAE, 2'b10);
        step();
        RdM = 0;
        #1; check("fwd_wb", ForwardAE, 2'b01);
        step();
        clear_inputs();

        // Load-use hazard, then the same with x0 destination.
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        #1; check("lw_stallf", StallF, 1'b1); check("lw_flushe", FlushE, 1'b1);
        step();
        RdE = 0;
        #1; check("lw_x0_stallf", StallF, 1'b0);
        step();
        // Branch wins over a coincident load-use.
        RdE = 7; PCSrcE = 1;
        #1; check("br_lw_stallf", StallF, 1'b0); check("br_lw_flushd", FlushD, 1'b1);
        step();
        clear_inputs();

        // Three-cycle memory wait.
        StatClr = 1;
        step();
        StatClr = 0;
        for (int c = 1; c <= 4; c++) begin
            MemReqM = 1;
            MemReadyM = (c == 4);
            #1;
            check("mw_stallm", StallM, c <= 3);
            check("mw_busy", MemBusy, c >= 2);
            step();
        end
        clear_inputs();
        #1; check("mw_count", StallCount, 3); check("mw_busy_end", MemBusy, 1'b0);
        step();

        // Branch during a memory stall, still taken on the release cycle.
        PCSrcE = 1; MemReqM = 1;
        #1; check("brms_flushd", FlushD, 1'b0);
        step();
        step();
        MemReadyM = 1;
        #1; check("brrel_flushd", FlushD, 1'b1); check("brrel_flushe", FlushE, 1'b1);
        step();
        clear_inputs();

        // Timeout after the wait limit; sticky until cleared.
        StatClr = 1;
        step();
        StatClr = 0;
        MemReqM = 1;
        for (int c = 0; c < 6; c++) step();
        MemReadyM = 1;
        step();
        clear_inputs();
        step();
        #1; check("to_sticky", MemTimeout, 1'b1);
        StatClr = 1;
        step();
        StatClr = 0;
        #1; check("to_cleared", MemTimeout, 1'b0);
        step();

        // Long wait saturates the stall counter.
        MemReqM = 1;
        for (int c = 0; c < 70; c++) step();
        #1; check("cnt_sat", StallCount, CNT_MAX);
        MemReadyM = 1;
        step();
        clear_inputs();

        // Reset asserted in the middle of a wait.
        MemReqM = 1;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rstw_busy", MemBusy, 1'b0);
        check("rstw_cnt", StallCount, 0);
        check("rstw_stallm", StallM, 1'b0);
        check("rstw_flushw", FlushW, 1'b0);
        model_reset();
        step();
        reset = 1'b1;
        MemReadyM = 1;
        #1; check("zw_stallf", StallF, 1'b0); check("zw_stallm", StallM, 1'b0);
        step();
        clear_inputs();

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            Rs1D = 5'($urandom_range(0, 7));
            Rs2D = 5'($urandom_range(0, 7));
            Rs1E = 5'($urandom_range(0, 7));
            Rs2E = 5'($urandom_range(0, 7));
            RdE  = 5'($urandom_range(0, 7));
            RdM  = 5'($urandom_range(0, 7));
            RdW  = 5'($urandom_range(0, 7));
            ResultSrcE = 2'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            PCSrcE     = ($urandom_range(0, 5) == 0);
            MemReqM    = m_waiting ? 1'b1 : 1'($urandom_range(0, 1));
            MemReadyM  = ($urandom_range(0, 2) == 0);
            StatClr    = ($urandom_range(0, 40) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
